debug_cmd_bridge: RTL and testbench
===================================

Name: debug_cmd_bridge

Overview:
- Synthesizable, parametrised successor to the simulation-only debug bus master. It takes debug commands from a host-side transport (UART/JTAG front end) over a valid/ready stream.
- Commands are queued in a command FIFO and replayed onto the CPU debug port using the established wr_en / req / ack protocol. Read data and command completions go back on a response stream.
- Adds configurable widths, queue depth and optional ack timeout with error reporting.

Parameters:
- ADDR_WIDTH, 2: debug register address width.
- DATA_WIDTH, 32: debug data width.
- CMD_DEPTH, 4: command FIFO entries; power of two, >= 2.
- CMD_ADDR, 0: address of the command register; a write here issues a req/ack transaction.
- TIMEOUT_CYCLES, 1023: maximum ISSUE cycles before abort. Only used with the timeout feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  FIFO can accept a command
- cmd_rnw  in  1  1 = read, 0 = write
- cmd_addr  in  ADDR_WIDTH  target debug register
- cmd_data  in  DATA_WIDTH  write value (ignored for reads)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_data  out  DATA_WIDTH  read data; 0 for command completions
- rsp_err  out  1  command timed out
- dbg_addr  out  ADDR_WIDTH  debug port address
- dbg_write_data  out  DATA_WIDTH  debug port write data
- dbg_read_data  in  DATA_WIDTH  debug port read data
- dbg_wr_en  out  1  debug register write strobe
- dbg_req  out  1  command request to CPU
- dbg_ack  in  1  CPU command acknowledge
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Single clock domain (clk). rst is synchronous and active-high.
- Reset: FIFO flushed, FSM to IDLE, working registers cleared. All outputs 0 except cmd_ready = 1 the cycle after reset deasserts.
- Command push: occurs when cmd_valid && cmd_ready. cmd_ready = !full, registered count based. A pop in the same cycle does not raise cmd_ready (no full-pass-through). The FIFO has no bypass.
- FSM states: IDLE, SETUP, READ_RESULT, ISSUE, RESPOND; one-hot encoded.
- IDLE:
  - If the FIFO is non-empty, pop the head into the working registers (rnw, addr, data) and go to SETUP. Otherwise stay in IDLE.
  - Latency: a command pushed in cycle N reaches SETUP in cycle N+2.
- dbg_addr and dbg_write_data are driven from the working registers. They are stable from SETUP until the FSM returns to IDLE.
- SETUP:
  - dbg_wr_en = !rnw, for exactly one cycle.
  - Next state: rnw -> READ_RESULT; write to CMD_ADDR -> ISSUE; any other write -> IDLE. Plain writes produce no response.
- READ_RESULT: capture dbg_read_data into rsp_data at the end of the cycle, rsp_err = 0, go to RESPOND.
- ISSUE:
  - dbg_req = (state == ISSUE) && !dbg_ack, combinational. req therefore drops in the same cycle ack is seen.
  - On dbg_ack: rsp_data = 0, rsp_err = 0, go to RESPOND. Ack outside ISSUE is ignored.
- RESPOND:
  - rsp_valid = 1. Hold rsp_data and rsp_err stable until rsp_ready, then go to IDLE.
  - If rsp_ready is already high on the first RESPOND cycle, the transfer completes that cycle.
- Ordering: strictly in order, one outstanding debug transaction at a time.
- Reset mid-operation: dbg_req, dbg_wr_en and rsp_valid are 0 from the cycle after rst is sampled high. Queued commands are discarded.

Optional Feature:
- Macro: DEBUG_CMD_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entering ISSUE and increments each ISSUE cycle without ack.
  - When the count reaches TIMEOUT_CYCLES without ack: dbg_req drops, rsp_data = 0, rsp_err = 1, go to RESPOND.
  - Ack on the same cycle as the timeout wins (rsp_err = 0).
- Not defined: ISSUE waits indefinitely for ack; rsp_err is tied 0; no counter logic exists.

Decomposition:
- Shared package debug_pkg:
  - state encoding localparams (one-hot);
  - command struct fields (rnw, addr, data), with widths derived from ADDR_WIDTH / DATA_WIDTH;
  - default CMD_ADDR.
- Sub-module sync_fifo (parametrised WIDTH, DEPTH; push/pop/full/empty/count) holds {rnw, addr, data}. The FSM and datapath stay in debug_cmd_bridge.

Test Plan:
- Read: push rnw=1, addr=2, with dbg_read_data = 0xDEADBEEF.
  - SETUP at N+2 with wr_en = 0.
  - rsp_valid at N+4 with rsp_data = 0xDEADBEEF, rsp_err = 0.
- Plain write: push rnw=0, addr=1, data=0x00001000.
  - dbg_wr_en high exactly one cycle with dbg_addr = 1, dbg_write_data = 0x1000.
  - No rsp_valid; busy drops at N+4.
- Command write: push addr=0, data=0x3, with ack 5 cycles after ISSUE entry.
  - dbg_req high 5 cycles, low in the ack cycle.
  - Then rsp_valid with rsp_data = 0, rsp_err = 0.
- Backpressure: push 6 commands back-to-back with CMD_DEPTH=4 and rsp_ready=0.
  - cmd_ready deasserts after 4 pushes.
  - RESPOND holds the first read response stable 10 cycles until rsp_ready.
  - All commands then execute in push order.
- Timeout (macro defined, TIMEOUT_CYCLES=8): command write, ack never asserted.
  - dbg_req high 8 cycles, then rsp_err = 1, rsp_data = 0.
- Reset mid-ISSUE with 2 commands queued: rst held 1 cycle.
  - dbg_req = 0 next cycle; FIFO empty; cmd_ready = 1; no response emitted.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the debug command bridge: one-hot FSM encoding
// and default widths/addresses used by the bridge and its command queue.
package debug_pkg;

    localparam int DBG_ADDR_W   = 2;
    localparam int DBG_DATA_W   = 32;
    localparam int DEF_CMD_ADDR = 0;
    localparam int ST_W         = 5;

    typedef enum logic [ST_W-1:0] {
        S_IDLE    = 5'b00001,
        S_SETUP   = 5'b00010,
        S_READ    = 5'b00100,
        S_ISSUE   = 5'b01000,
        S_RESPOND = 5'b10000
    } state_e;

    typedef struct packed {
        logic                  rnw;
        logic [DBG_ADDR_W-1:0] addr;
        logic [DBG_DATA_W-1:0] data;
    } dbg_cmd_t;

endpackage

// File: rtl/debug_cmd_bridge_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; no bypass path,
// so data pushed in a cycle is visible at the head the next cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rptr_q];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/debug_cmd_bridge.sv
// Host-stream to CPU debug port bridge with in-order command queue.
// Define DEBUG_CMD_BRIDGE_TIMEOUT_EN to abort unacked ISSUE with rsp_err.
module debug_cmd_bridge
    import debug_pkg::*;
#(
    parameter int ADDR_WIDTH     = DBG_ADDR_W,
    parameter int DATA_WIDTH     = DBG_DATA_W,
    parameter int CMD_DEPTH      = 4,
    parameter int CMD_ADDR       = DEF_CMD_ADDR,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rnw,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_write_data,
    input  logic [DATA_WIDTH-1:0] dbg_read_data,
    output logic                  dbg_wr_en,
    output logic                  dbg_req,
    input  logic                  dbg_ack,
    output logic                  busy
);
    typedef struct packed {
        logic                  rnw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } cmd_t;

    localparam int CW = $bits(cmd_t);

    state_e          state_q, state_d;
    cmd_t            cmd_q, cmd_d;
    cmd_t            push_cmd, head_cmd;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic            busy_q, busy_d;
    logic            fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_rdata;
    logic [$clog2(CMD_DEPTH):0] fifo_count;

    assign push_cmd       = {cmd_rnw, cmd_addr, cmd_data};
    assign head_cmd       = fifo_rdata;
    assign cmd_ready      = !fifo_full;
    assign dbg_addr       = cmd_q.addr;
    assign dbg_write_data = cmd_q.data;
    assign rsp_data       = rsp_data_q;
    assign busy           = busy_q;

    sync_fifo #(
        .WIDTH (CW),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .pop   (fifo_pop),
        .wdata (push_cmd),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef DEBUG_CMD_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rsp_err_q, rsp_err_d;
    logic          tmo_hit;

    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES));
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        rsp_data_d = rsp_data_q;
        fifo_pop   = 1'b0;
        dbg_wr_en  = 1'b0;
        dbg_req    = 1'b0;
        rsp_valid  = 1'b0;
`ifdef DEBUG_CMD_BRIDGE_TIMEOUT_EN
        tmo_d      = tmo_q;
        rsp_err_d  = rsp_err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = head_cmd;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                dbg_wr_en = !cmd_q.rnw;
                if (cmd_q.rnw) begin
                    state_d = S_READ;
                end else if (cmd_q.addr == ADDR_WIDTH'(CMD_ADDR)) begin
                    state_d = S_ISSUE;
`ifdef DEBUG_CMD_BRIDGE_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                rsp_data_d = dbg_read_data;
`ifdef DEBUG_CMD_BRIDGE_TIMEOUT_EN
                rsp_err_d  = 1'b0;
`endif
                state_d    = S_RESPOND;
            end
            S_ISSUE: begin
`ifdef DEBUG_CMD_BRIDGE_TIMEOUT_EN
                // ack on the timeout cycle still counts as success
                dbg_req = !dbg_ack && !tmo_hit;
                if (dbg_ack) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESPOND;
                end else if (tmo_hit) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESPOND;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`else
                dbg_req = !dbg_ack;
                if (dbg_ack) begin
                    rsp_data_d = '0;
                    state_d    = S_RESPOND;
                end
`endif
            end
            S_RESPOND: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = !fifo_empty || (state_q != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            rsp_data_q <= '0;
            busy_q     <= 1'b0;
`ifdef DEBUG_CMD_BRIDGE_TIMEOUT_EN
            tmo_q      <= '0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            rsp_data_q <= rsp_data_d;
            busy_q     <= busy_d;
`ifdef DEBUG_CMD_BRIDGE_TIMEOUT_EN
            tmo_q      <= tmo_d;
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_debug_cmd_bridge.sv
// Directed scoreboard bench for debug_cmd_bridge: host pushes, CPU
// debug-port model with programmable ack delay, in-order response checks.
module tb_debug_cmd_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [1:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic [1:0]  dbg_addr;
    logic [31:0] dbg_write_data, dbg_read_data;
    logic        dbg_wr_en, dbg_req, dbg_ack, busy;

    int vectors = 0;
    int miscompares = 0;

    logic [32:0] exp_q[$];
    logic [31:0] cpu_regs[4];
    logic [31:0] exp_regs[4];
    int          ack_delay = -1;
    int          ack_cnt = 0;
    bit          exp_tmo = 1'b0;
    int          hold_cnt = 0;
    int          max_hold = 0;
    logic [32:0] hold_val;

    always #5 clk = ~clk;

    debug_cmd_bridge #(
        .ADDR_WIDTH     (2),
        .DATA_WIDTH     (32),
        .CMD_DEPTH      (4),
        .CMD_ADDR       (0),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_rnw        (cmd_rnw),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .dbg_addr       (dbg_addr),
        .dbg_write_data (dbg_write_data),
        .dbg_read_data  (dbg_read_data),
        .dbg_wr_en      (dbg_wr_en),
        .dbg_req        (dbg_req),
        .dbg_ack        (dbg_ack),
        .busy           (busy)
    );

    // CPU debug register file
    assign dbg_read_data = cpu_regs[dbg_addr];

    always @(posedge clk) begin
        if (rst) begin
            cpu_regs[0] <= 32'h0;
            cpu_regs[1] <= 32'h1111_1111;
            cpu_regs[2] <= 32'hDEAD_BEEF;
            cpu_regs[3] <= 32'h3333_3333;
        end else if (dbg_wr_en) begin
            cpu_regs[dbg_addr] <= dbg_write_data;
        end
    end

    task automatic model_reset();
        exp_regs[0] = 32'h0;
        exp_regs[1] = 32'h1111_1111;
        exp_regs[2] = 32'hDEAD_BEEF;
        exp_regs[3] = 32'h3333_3333;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // ack responder: acks ack_delay cycles after ISSUE entry, never if < 0
    initial begin
        dbg_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (dbg_ack) begin
                dbg_ack = 1'b0;
                ack_cnt = 0;
            end else if (dbg_req && ack_delay >= 0) begin
                if (ack_cnt == ack_delay) dbg_ack = 1'b1;
                else ack_cnt++;
            end else begin
                ack_cnt = 0;
            end
        end
    end

    // response monitor: in-order scoreboard plus hold-stability check
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rsp_valid && !rst) begin
                if (rsp_ready) begin
                    vectors++;
                    assert (exp_q.size() != 0) else begin
                        miscompares++;
                        $error("FAIL rsp_unexpected: observed %0h expected none",
                               {rsp_err, rsp_data});
                    end
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("rsp_data", rsp_data, e[31:0]);
                        chk("rsp_err", rsp_err, e[32]);
                    end
                    if (hold_cnt > max_hold) max_hold = hold_cnt;
                    hold_cnt = 0;
                end else begin
                    if (hold_cnt > 0)
                        chk("rsp_hold", {rsp_err, rsp_data}, hold_val);
                    else
                        hold_val = {rsp_err, rsp_data};
                    hold_cnt++;
                end
            end
        end
    end

    task automatic try_push(input logic rnw, input logic [1:0] a,
                            input logic [31:0] d, output logic acc);
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = a;
        cmd_data  = d;
        @(negedge clk);
        acc = cmd_ready;
        if (acc) begin
            if (rnw) begin
                exp_q.push_back({1'b0, exp_regs[a]});
            end else begin
                exp_regs[a] = d;
                if (a == 2'd0) exp_q.push_back({exp_tmo, 32'h0});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_wait(input logic rnw, input logic [1:0] a,
                             input logic [31:0] d);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 64; i++) begin
            try_push(rnw, a, d, acc);
            if (acc) break;
        end
        chk("push_accept", acc, 1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   reqs;
        bit   got;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_rnw = 1'b0;
        cmd_addr = '0;
        cmd_data = '0;
        rsp_ready = 1'b1;
        model_reset();
        nxt();
        nxt();
        rst = 1'b0;
        mid();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_dbg_req", dbg_req, 0);
        chk("rst_wr_en", dbg_wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_dbg_addr", dbg_addr, 0);
        nxt();

        // read addr 2
        try_push(1'b1, 2'd2, 32'h0, acc);
        cmd_valid = 1'b0;
        chk("rd_accept", acc, 1);
        nxt();
        mid();
        chk("rd_setup_wren", dbg_wr_en, 0);
        chk("rd_setup_addr", dbg_addr, 2);
        chk("rd_busy", busy, 1);
        nxt();
        mid();
        chk("rd_not_yet", rsp_valid, 0);
        nxt();
        mid();
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_data", rsp_data, 32'hDEAD_BEEF);
        nxt();

        // plain write addr 1
        try_push(1'b0, 2'd1, 32'h0000_1000, acc);
        cmd_valid = 1'b0;
        mid();
        chk("wr_wren_pre", dbg_wr_en, 0);
        nxt();
        mid();
        chk("wr_wren", dbg_wr_en, 1);
        chk("wr_addr", dbg_addr, 1);
        chk("wr_data", dbg_write_data, 32'h1000);
        nxt();
        mid();
        chk("wr_wren_post", dbg_wr_en, 0);
        chk("wr_busy_n3", busy, 1);
        nxt();
        mid();
        chk("wr_busy_n4", busy, 0);
        chk("wr_no_rsp", rsp_valid, 0);
        nxt();

        // command write, ack 5 cycles after ISSUE entry
        ack_delay = 5;
        try_push(1'b0, 2'd0, 32'h3, acc);
        cmd_valid = 1'b0;
        nxt();
        nxt();
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("cw_req_high", dbg_req, 1);
            nxt();
        end
        mid();
        chk("cw_req_ack_cycle", dbg_req, 0);
        chk("cw_ack", dbg_ack, 1);
        nxt();
        mid();
        chk("cw_rsp_valid", rsp_valid, 1);
        chk("cw_rsp_data", rsp_data, 0);
        nxt();

        // backpressure: FSM parked in RESPOND while the FIFO fills
        ack_delay = 2;
        rsp_ready = 1'b0;
        push_wait(1'b1, 2'd2, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mid();
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            nxt();
        end
        chk("bp_respond", got, 1);
        nxt();
        try_push(1'b0, 2'd3, 32'hA5A5, acc);
        chk("bp_push1", acc, 1);
        try_push(1'b1, 2'd3, 32'h0, acc);
        chk("bp_push2", acc, 1);
        try_push(1'b0, 2'd0, 32'h7, acc);
        chk("bp_push3", acc, 1);
        try_push(1'b1, 2'd1, 32'h0, acc);
        chk("bp_push4", acc, 1);
        for (int i = 0; i < 5; i++) begin
            try_push(1'b0, 2'd3, 32'h5A5A, acc);
            chk("bp_full", acc, 0);
        end
        rsp_ready = 1'b1;
        push_wait(1'b0, 2'd3, 32'h5A5A);
        push_wait(1'b1, 2'd3, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            mid();
            if (exp_q.size() == 0 && !busy) begin
                got = 1'b1;
                break;
            end
            nxt();
        end
        chk("bp_drain", got, 1);
        chk("bp_hold_len", max_hold, 10);
        nxt();

`ifdef DEBUG_CMD_BRIDGE_TIMEOUT_EN
        // command write never acked
        ack_delay = -1;
        exp_tmo = 1'b1;
        push_wait(1'b0, 2'd0, 32'h9);
        exp_tmo = 1'b0;
        reqs = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            mid();
            if (dbg_req) reqs++;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            nxt();
        end
        chk("tmo_rsp", got, 1);
        chk("tmo_req_cycles", reqs, 8);
        chk("tmo_err", rsp_err, 1);
        chk("tmo_data", rsp_data, 0);
        nxt();
`endif

        // reset mid-ISSUE with two reads queued
        ack_delay = -1;
        push_wait(1'b0, 2'd0, 32'h5);
        push_wait(1'b1, 2'd2, 32'h0);
        push_wait(1'b1, 2'd1, 32'h0);
        mid();
        chk("rs_req_before", dbg_req, 1);
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        exp_q.delete();
        model_reset();
        mid();
        chk("rs_req_after", dbg_req, 0);
        chk("rs_cmd_ready", cmd_ready, 1);
        chk("rs_rsp_valid", rsp_valid, 0);
        for (int i = 0; i < 8; i++) begin
            nxt();
            mid();
            chk("rs_idle_busy", busy, 0);
            chk("rs_idle_wren", dbg_wr_en, 0);
        end
        nxt();

        chk("all_rsp_seen", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
